gpio_core: RTL

- Parametrised general-purpose I/O core for an MMIO slot.
- Provides:
  - an output register with atomic set/clear/toggle aliases;
  - a per-bit direction register;
  - a synchronised input path;
  - per-bit rising/falling edge detection with sticky, maskable status and a single level interrupt.
- Sits behind the MMIO slot decoder like every other slot core; pins go to the top-level tristate/pad logic.

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_in_sync.sv | 39 +++
 rtl/gpio_core.sv | 110 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Register map shared by the GPIO slot core and its sub-blocks.
// Offsets are word addresses on the 5-bit slot address bus.
package gpio_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_DATA   = 5'd0;
    localparam reg_addr_t REG_SET    = 5'd1;
    localparam reg_addr_t REG_CLR    = 5'd2;
    localparam reg_addr_t REG_TOG    = 5'd3;
    localparam reg_addr_t REG_DIR    = 5'd4;
    localparam reg_addr_t REG_DIN    = 5'd5;
    localparam reg_addr_t REG_RISE   = 5'd6;
    localparam reg_addr_t REG_FALL   = 5'd7;
    localparam reg_addr_t REG_STATUS = 5'd8;
    localparam reg_addr_t REG_MASK   = 5'd9;

endpackage

// File: rtl/gpio_in_sync.sv
// Pin input synchroniser with a previous-value flop and raw (unmasked) edge outputs.
// A din change reaches sync after SYNC_STAGES clocks; the edge pulses one cycle later in status.
module gpio_in_sync
    import gpio_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] stage_q [SYNC_STAGES];
    logic [W-1:0] sync_d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            sync_d_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            sync_d_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync = stage_q[SYNC_STAGES-1];
    assign rise = sync & ~sync_d_q;
    assign fall = ~sync & sync_d_q;

endmodule

// File: rtl/gpio_core.sv
// GPIO slot core: output data with set/clear/toggle aliases, direction, synchronised input,
// sticky maskable edge status and a level interrupt derived only from registered state.
module gpio_core
    import gpio_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [W-1:0] DOUT_RST   = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] dir,
    output logic         irq
);

    logic         wr;
    logic [W-1:0] wd;
    logic [W-1:0] sync, rise_raw, fall_raw, clr_mask;
    logic [W-1:0] dout_q, dout_d, dir_q, dir_d;
    logic [W-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [W-1:0] status_q, status_d, mask_q, mask_d;
    logic         unused_bits;

    assign wr = cs & write;
    assign wd = wr_data[W-1:0];
    // Reads have no side effects and upper write bits are dropped.
    assign unused_bits = ^{read, wr_data};

    gpio_in_sync #(
        .W           (W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .sync  (sync),
        .rise  (rise_raw),
        .fall  (fall_raw)
    );

    always_comb begin
        dout_d    = dout_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        clr_mask  = '0;
        if (wr) begin
            case (addr)
                REG_DATA:   dout_d    = wd;
                REG_SET:    dout_d    = dout_q | wd;
                REG_CLR:    dout_d    = dout_q & ~wd;
                REG_TOG:    dout_d    = dout_q ^ wd;
                REG_DIR:    dir_d     = wd;
                REG_RISE:   rise_en_d = wd;
                REG_FALL:   fall_en_d = wd;
                REG_STATUS: clr_mask  = wd;
                REG_MASK:   mask_d    = wd;
                default:    ;
            endcase
        end
        // New edges are OR-ed in after the clear so a same-cycle edge survives W1C.
        status_d = (status_q & ~clr_mask) | (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q    <= DOUT_RST;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            mask_q    <= '0;
        end else begin
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_DATA:   rd_data[W-1:0] = dout_q;
            REG_DIR:    rd_data[W-1:0] = dir_q;
            REG_DIN:    rd_data[W-1:0] = sync;
            REG_RISE:   rd_data[W-1:0] = rise_en_q;
            REG_FALL:   rd_data[W-1:0] = fall_en_q;
            REG_STATUS: rd_data[W-1:0] = status_q;
            REG_MASK:   rd_data[W-1:0] = mask_q;
            default:    rd_data = '0;
        endcase
    end

    assign dout = dout_q;
    assign dir  = dir_q;
    assign irq  = |(status_q & mask_q);

endmodule
